sc_ioport: RTL and testbench
============================

SC_IOPORT -- requirements
Module: sc_ioport

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; port names and order are as listed below.
REQ-002 clock  in  1  sole clock; all state updates on the rising edge.
REQ-003 resetn  in  1  synchronous active-low reset; sampled on the clock rising edge.
REQ-004 addr  in  32  CPU data address (the aluout bus).
REQ-005 datain  in  32  CPU store data.
REQ-006 wmem  in  1  CPU store strobe.
REQ-007 sw  in  10  raw asynchronous slide switches.
REQ-008 key  in  3  raw asynchronous push-buttons, active-low; bit i is KEY[i+1].
REQ-009 io_sel  out  1  high when addr hits the I/O window; the top level muxes dataout over memout and gates the dmem write with it.
REQ-010 dataout  out  32  I/O read data.
REQ-011 led  out  10  LED register.
REQ-012 hex0..hex5  out  7 each  seven-segment digits, active-low segments {g,f,e,d,c,b,a}.

Function
REQ-013 io_sel SHALL be 1 iff addr[31:6] == 26'h3 (byte range 0xC0-0xFF); register index = addr[5:2].
REQ-014 Register map (index: name, access):
- 0: SW, RO, {22'b0, sw_sync}.
- 1: KEY, RO, {29'b0, pressed}.
- 2: KEY_EDGE, write-1-to-clear.
- 3: LED, RW, bits [9:0].
- 4: HEX, RW, bits [23:0].
- 5: TCOUNT, RW.
- 6: TCTRL, RW; bit0 enable, bit1 expired (write-1-to-clear).
- 7: TRELOAD, RW.
- 8-15: read 0; writes ignored.
REQ-015 Reads SHALL be combinational from addr. dataout SHALL be 0 when io_sel is 0. Unused bits SHALL read 0.
REQ-016 A write SHALL take effect at the rising edge where wmem=1 and io_sel=1. Only the defined bits are stored.
REQ-017 Each sw and key bit SHALL pass through a two-flop synchronizer. Keys are inverted so that pressed=1.
REQ-018 A sw change SHALL be visible on SW reads after the 2nd rising edge.
REQ-019 prev SHALL be pressed delayed by one cycle. KEY_EDGE[i] SHALL set when pressed[i]=1 and prev[i]=0, i.e. it reads 1 after the 3rd rising edge following a press.
REQ-020 KEY_EDGE bits SHALL be sticky until cleared. If a set and a clear of the same bit occur in the same cycle, the set SHALL win.
REQ-021 Timer behaviour:
- When enable=1 and TCOUNT!=0: TCOUNT decrements by 1 per cycle.
- When enable=1 and TCOUNT==0: expired sets and TCOUNT loads TRELOAD in that cycle.
- With TRELOAD=0, expired therefore re-asserts every cycle.
- When enable=0: TCOUNT holds.
REQ-022 A CPU write to TCOUNT SHALL override a same-cycle decrement or reload.
REQ-023 An expire event SHALL override a same-cycle write-1-to-clear of expired.
REQ-024 Writing TCTRL with bit1=0 SHALL leave expired unchanged.
REQ-025 Seven-segment outputs:
- hexN SHALL be the combinational decode of HEX[4N+3:4N].
- Digits 0-F use the standard active-low patterns (0 -> 7'b1000000, 1 -> 7'b1111001, A -> 7'b0001000, F -> 7'b0001110).
REQ-026 Arithmetic SHALL be 32-bit unsigned. TCOUNT SHALL never wrap below 0; it reloads instead.

Reset
REQ-027 When resetn=0 at a rising edge, all of the following SHALL clear to 0:
- synchronizers, prev, KEY_EDGE;
- LED, HEX;
- TCOUNT, TRELOAD, enable, expired.
REQ-028 Consequently, after reset: led=0 and every hexN=7'b1000000.
REQ-029 Reset SHALL take priority over any same-cycle write or timer event. A timer mid-count SHALL stop and clear.
REQ-030 io_sel and dataout SHALL remain combinational during reset and reflect the cleared registers.

Verification
REQ-031 Reset, then read addr 0xCC and 0xD0 -> 0 and 0; hex0..hex5 all 7'b1000000; led=0.
REQ-032 Store 0x3FF to 0xCC and 0x00ABCDEF to 0xD0, then store 0x123 to 0x1CC (not I/O) -> led=10'h3FF; hex0=F, hex1=E, hex2=D, hex3=C, hex4=B, hex5=A patterns; io_sel=0 for 0x1CC and led unchanged.
REQ-033 sw toggled 0 -> 10'h2A5 -> read 0xC0 returns 0 after 1 edge and 0x2A5 after 2 edges.
REQ-034 key[0] driven low and held:
- read 0xC8 -> bit0=1 from the 3rd edge on;
- store 1 to 0xC8 -> bit0=0 with no re-set while the key stays held;
- release and press again -> bit0=1 again.
REQ-035 Timer: store 3 to 0xDC, 2 to 0xD4, 1 to 0xD8 -> TCOUNT reads 2,1,0,3,2,1,0,3…; expired=1 from the first reload onward; store 0x2 to 0xD8 in a non-expiring cycle -> reads 0 and enable=0; a 0xD4 write during counting overrides the decrement.
REQ-036 Timer running with TRELOAD=0, then pulse resetn=0 for one cycle -> TCOUNT, TCTRL, LED, HEX all read 0 on the next cycle and no expire occurs afterwards.

Source files
------------

// File: rtl/sc_ioport.sv
// Memory-mapped I/O port for a single-cycle CPU: switches, keys with edge capture,
// LEDs, six seven-segment digits and a reloading down-counter timer.
module sc_ioport (
   input  logic        clock,
   input  logic        resetn,
   input  logic [31:0] addr,
   input  logic [31:0] datain,
   input  logic        wmem,
   input  logic [9:0]  sw,
   input  logic [2:0]  key,
   output logic        io_sel,
   output logic [31:0] dataout,
   output logic [9:0]  led,
   output logic [6:0]  hex0,
   output logic [6:0]  hex1,
   output logic [6:0]  hex2,
   output logic [6:0]  hex3,
   output logic [6:0]  hex4,
   output logic [6:0]  hex5
);

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned SW_W    = 10;
   localparam int unsigned KEY_W   = 3;
   localparam int unsigned HEX_W   = 24;
   localparam int unsigned IDX_W   = 4;
   localparam int unsigned PAGE_W  = 26;

   localparam logic [PAGE_W-1:0] IO_PAGE = PAGE_W'(3);

   localparam logic [IDX_W-1:0] IDX_SW      = IDX_W'(0);
   localparam logic [IDX_W-1:0] IDX_KEY     = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_KEDGE   = IDX_W'(2);
   localparam logic [IDX_W-1:0] IDX_LED     = IDX_W'(3);
   localparam logic [IDX_W-1:0] IDX_HEX     = IDX_W'(4);
   localparam logic [IDX_W-1:0] IDX_TCOUNT  = IDX_W'(5);
   localparam logic [IDX_W-1:0] IDX_TCTRL   = IDX_W'(6);
   localparam logic [IDX_W-1:0] IDX_TRELOAD = IDX_W'(7);

   logic [SW_W-1:0]   sw_meta;
   logic [SW_W-1:0]   sw_sync;
   logic [KEY_W-1:0]  key_meta;
   logic [KEY_W-1:0]  pressed;
   logic [KEY_W-1:0]  prev;
   logic [KEY_W-1:0]  key_edge;
   logic [HEX_W-1:0]  hex_reg;
   logic [DATA_W-1:0] tcount;
   logic [DATA_W-1:0] treload;
   logic              enable;
   logic              expired;

   logic [IDX_W-1:0]  reg_idx;
   logic              wr_en;
   logic              expire_evt;
   logic [KEY_W-1:0]  key_edge_clr;
   logic [KEY_W-1:0]  key_edge_nxt;
   logic [DATA_W-1:0] tcount_nxt;
   logic              expired_nxt;
   logic              unused_addr_bits;

   // Byte offset within a word is irrelevant to the register file.
   assign unused_addr_bits = ^addr[1:0];

   assign io_sel  = (addr[31:6] == IO_PAGE);
   assign reg_idx = addr[5:2];
   assign wr_en   = wmem & io_sel;

   // Timer and edge-capture next state; set/expire beat same-cycle clears,
   // a CPU write to TCOUNT beats the timer's own update.
   always_comb begin
      expire_evt   = enable && (tcount == '0);
      key_edge_clr = '0;
      tcount_nxt   = tcount;
      expired_nxt  = expired;

      if (wr_en && (reg_idx == IDX_KEDGE))
         key_edge_clr = datain[KEY_W-1:0];
      key_edge_nxt = (key_edge & ~key_edge_clr) | (pressed & ~prev);

      if (enable) begin
         if (tcount == '0)
            tcount_nxt = treload;
         else
            tcount_nxt = tcount - DATA_W'(1);
      end
      if (wr_en && (reg_idx == IDX_TCOUNT))
         tcount_nxt = datain;

      if (wr_en && (reg_idx == IDX_TCTRL) && datain[1])
         expired_nxt = 1'b0;
      if (expire_evt)
         expired_nxt = 1'b1;
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         sw_meta  <= '0;
         sw_sync  <= '0;
         key_meta <= '0;
         pressed  <= '0;
         prev     <= '0;
         key_edge <= '0;
         led      <= '0;
         hex_reg  <= '0;
         tcount   <= '0;
         treload  <= '0;
         enable   <= 1'b0;
         expired  <= 1'b0;
      end else begin
         sw_meta  <= sw;
         sw_sync  <= sw_meta;
         key_meta <= ~key;
         pressed  <= key_meta;
         prev     <= pressed;
         key_edge <= key_edge_nxt;
         tcount   <= tcount_nxt;
         expired  <= expired_nxt;
         if (wr_en) begin
            unique case (reg_idx)
               IDX_LED:     led     <= datain[SW_W-1:0];
               IDX_HEX:     hex_reg <= datain[HEX_W-1:0];
               IDX_TCTRL:   enable  <= datain[0];
               IDX_TRELOAD: treload <= datain;
               default: ;
            endcase
         end
      end
   end

   // Combinational register read; unmapped slots and non-I/O addresses read 0.
   always_comb begin
      dataout = '0;
      if (io_sel) begin
         unique case (reg_idx)
            IDX_SW:      dataout = DATA_W'(sw_sync);
            IDX_KEY:     dataout = DATA_W'(pressed);
            IDX_KEDGE:   dataout = DATA_W'(key_edge);
            IDX_LED:     dataout = DATA_W'(led);
            IDX_HEX:     dataout = DATA_W'(hex_reg);
            IDX_TCOUNT:  dataout = tcount;
            IDX_TCTRL:   dataout = DATA_W'({expired, enable});
            IDX_TRELOAD: dataout = treload;
            default:     dataout = '0;
         endcase
      end
   end

   // Active-low {g,f,e,d,c,b,a} hex digit decode.
   function automatic logic [6:0] seg7(input logic [3:0] nib);
      logic [6:0] s;
      unique case (nib)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   assign hex0 = seg7(hex_reg[3:0]);
   assign hex1 = seg7(hex_reg[7:4]);
   assign hex2 = seg7(hex_reg[11:8]);
   assign hex3 = seg7(hex_reg[15:12]);
   assign hex4 = seg7(hex_reg[19:16]);
   assign hex5 = seg7(hex_reg[23:20]);

endmodule

// File: tb/tb_sc_ioport.sv
// Self-checking bench for sc_ioport: register-map vectors, directed timer/key
// sequences and randomized traffic against a delay-line/arithmetic reference model.
module tb_sc_ioport;

   logic        clock = 1'b0;
   logic        resetn;
   logic [31:0] addr;
   logic [31:0] datain;
   logic        wmem;
   logic [9:0]  sw;
   logic [2:0]  key;
   logic        io_sel;
   logic [31:0] dataout;
   logic [9:0]  led;
   logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;

   int n_chk  = 0;
   int n_fail = 0;

   sc_ioport dut (
      .clock(clock), .resetn(resetn), .addr(addr), .datain(datain), .wmem(wmem),
      .sw(sw), .key(key), .io_sel(io_sel), .dataout(dataout), .led(led),
      .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5)
   );

   always #5 clock = ~clock;

   typedef struct {
      string       name;
      logic [31:0] a;
      logic [31:0] wdata;
      logic        do_wr;
      logic        exp_sel;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs[$];

   // Reference model state
   logic [9:0]  m_led;
   logic [23:0] m_hex;
   logic [31:0] m_cnt, m_rel;
   logic        m_en, m_exp;
   logic [2:0]  m_kedge;
   logic [9:0]  sw_q[$];
   logic [2:0]  key_q[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [6:0] seg(input logic [3:0] v);
      logic [6:0] t[16];
      t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      return t[v];
   endfunction

   function automatic logic [41:0] hex_all(input logic [23:0] h);
      return {seg(h[23:20]), seg(h[19:16]), seg(h[15:12]),
              seg(h[11:8]), seg(h[7:4]), seg(h[3:0])};
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      addr = a; datain = d; wmem = 1'b1;
      step();
      wmem = 1'b0;
   endtask

   task automatic rd(input string nm, input logic [31:0] a, input logic [31:0] exp);
      addr = a; wmem = 1'b0;
      #1;
      chk(nm, 64'(dataout), 64'(exp));
   endtask

   task automatic do_reset();
      resetn = 1'b0; wmem = 1'b0;
      step();
      resetn = 1'b1;
   endtask

   // Model: synchronizer outputs are just the inputs delayed through a queue.
   function automatic logic [2:0] m_pressed();
      return ~key_q[key_q.size()-2];
   endfunction

   function automatic logic [2:0] m_prev();
      return ~key_q[key_q.size()-3];
   endfunction

   function automatic logic [31:0] m_read(input logic [31:0] a);
      if (a[31:6] != 26'h3) return 32'h0;
      case (a[5:2])
         4'd0: return 32'(sw_q[sw_q.size()-2]);
         4'd1: return 32'(m_pressed());
         4'd2: return 32'(m_kedge);
         4'd3: return 32'(m_led);
         4'd4: return 32'(m_hex);
         4'd5: return m_cnt;
         4'd6: return 32'({m_exp, m_en});
         4'd7: return m_rel;
         default: return 32'h0;
      endcase
   endfunction

   task automatic m_reset();
      m_led = '0; m_hex = '0; m_cnt = '0; m_rel = '0; m_en = 0; m_exp = 0; m_kedge = '0;
      sw_q = {}; key_q = {};
      for (int i = 0; i < 4; i++) begin
         sw_q.push_back(10'h0);
         key_q.push_back(3'b111);
      end
   endtask

   task automatic m_edge(input logic [31:0] a, input logic [31:0] d, input logic w,
                         input logic [9:0] swv, input logic [2:0] keyv);
      logic        hit;
      logic [3:0]  idx;
      logic [31:0] ncnt;
      logic        nexp;
      logic [2:0]  clr;
      hit  = w && (a[31:6] == 26'h3);
      idx  = a[5:2];
      ncnt = m_cnt;
      nexp = m_exp;
      if (m_en) ncnt = (m_cnt == 0) ? m_rel : m_cnt - 1;
      if (hit && idx == 4'd5) ncnt = d;
      if (hit && idx == 4'd6 && d[1]) nexp = 1'b0;
      if (m_en && m_cnt == 0) nexp = 1'b1;
      clr = (hit && idx == 4'd2) ? d[2:0] : 3'b000;
      m_kedge = (m_kedge & ~clr) | (m_pressed() & ~m_prev());
      if (hit && idx == 4'd3) m_led = d[9:0];
      if (hit && idx == 4'd4) m_hex = d[23:0];
      if (hit && idx == 4'd6) m_en = d[0];
      if (hit && idx == 4'd7) m_rel = d;
      m_cnt = ncnt;
      m_exp = nexp;
      sw_q.push_back(swv);   void'(sw_q.pop_front());
      key_q.push_back(keyv); void'(key_q.pop_front());
   endtask

   initial begin
      logic [31:0] seq_cnt[8];
      logic [31:0] seq_ctl[8];
      logic [31:0] ra, rd_v;
      logic        rw;

      resetn = 1'b0; addr = '0; datain = '0; wmem = 1'b0; sw = '0; key = 3'b111;
      step(); step();
      do_reset();

      // Reset state
      rd("rst_led_rd", 32'hCC, 32'h0);
      rd("rst_hex_rd", 32'hD0, 32'h0);
      chk("rst_hex_pins", {hex5, hex4, hex3, hex2, hex1, hex0}, {6{7'b1000000}});
      chk("rst_led_pin", 64'(led), 64'h0);

      // Register map vectors
      vecs.push_back('{"sw_ro",      32'hC0, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0});
      vecs.push_back('{"key_ro",     32'hC4, 32'h7,         1'b1, 1'b1, 32'h0});
      vecs.push_back('{"led_mask",   32'hCC, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h3FF});
      vecs.push_back('{"hex_mask",   32'hD0, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'hFF_FFFF});
      vecs.push_back('{"treload",    32'hDC, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'hDEAD_BEEF});
      vecs.push_back('{"tcount_hold",32'hD4, 32'h1234_5678, 1'b1, 1'b1, 32'h1234_5678});
      vecs.push_back('{"unmapped8",  32'hE0, 32'h55,        1'b1, 1'b1, 32'h0});
      vecs.push_back('{"unmapped15", 32'hFC, 32'hAA,        1'b1, 1'b1, 32'h0});
      vecs.push_back('{"below_win",  32'hBC, 32'h0,         1'b0, 1'b0, 32'h0});
      vecs.push_back('{"above_win",  32'h100, 32'h0,        1'b0, 1'b0, 32'h0});
      vecs.push_back('{"high_alias", 32'hFFFF_FFC0, 32'h0,  1'b0, 1'b0, 32'h0});
      vecs.push_back('{"byte_off",   32'hCD, 32'h0,         1'b0, 1'b1, 32'h3FF});
      vecs.push_back('{"tctrl_bit2", 32'hD8, 32'h4,         1'b1, 1'b1, 32'h0});
      vecs.push_back('{"nonio_wr",   32'h1CC, 32'h0,        1'b1, 1'b0, 32'h0});
      vecs.push_back('{"led_kept",   32'hCC, 32'h0,         1'b0, 1'b1, 32'h3FF});
      foreach (vecs[i]) begin
         if (vecs[i].do_wr) wr(vecs[i].a, vecs[i].wdata);
         addr = vecs[i].a; wmem = 1'b0;
         #1;
         chk({vecs[i].name, "_sel"}, 64'(io_sel), 64'(vecs[i].exp_sel));
         chk({vecs[i].name, "_rd"}, 64'(dataout), 64'(vecs[i].exp_rd));
      end

      // LED / HEX stores plus a non-I/O store
      do_reset();
      wr(32'hCC, 32'h3FF);
      wr(32'hD0, 32'h00AB_CDEF);
      addr = 32'h1CC; datain = 32'h123; wmem = 1'b1;
      #1;
      chk("nonio_sel", 64'(io_sel), 64'h0);
      step();
      wmem = 1'b0;
      chk("led_3ff", 64'(led), 64'h3FF);
      chk("hex_abcdef", {hex5, hex4, hex3, hex2, hex1, hex0},
          {7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110});

      // Switch synchronizer latency
      sw = 10'h2A5;
      addr = 32'hC0;
      step();
      rd("sw_edge1", 32'hC0, 32'h0);
      step();
      rd("sw_edge2", 32'hC0, 32'h2A5);
      sw = '0;
      step(); step();

      // Key press edge capture, clear, re-press with same-cycle clear
      key = 3'b110;
      step(); rd("kedge_e1", 32'hC8, 32'h0);
      step(); rd("kedge_e2", 32'hC8, 32'h0);
      rd("key_pressed", 32'hC4, 32'h1);
      step(); rd("kedge_e3", 32'hC8, 32'h1);
      wr(32'hC8, 32'h1);
      rd("kedge_clr", 32'hC8, 32'h0);
      step(); step();
      rd("kedge_held", 32'hC8, 32'h0);
      key = 3'b111;
      repeat (4) step();
      rd("kedge_rel", 32'hC8, 32'h0);
      key = 3'b110;
      step(); step();
      wr(32'hC8, 32'h1);
      rd("kedge_setwins", 32'hC8, 32'h1);
      key = 3'b111;
      repeat (4) step();

      // Timer reload sequence
      do_reset();
      wr(32'hDC, 32'd3);
      wr(32'hD4, 32'd2);
      wr(32'hD8, 32'd1);
      seq_cnt = '{2, 1, 0, 3, 2, 1, 0, 3};
      seq_ctl = '{1, 1, 1, 3, 3, 3, 3, 3};
      for (int i = 0; i < 8; i++) begin
         rd($sformatf("tcount_seq%0d", i), 32'hD4, seq_cnt[i]);
         rd($sformatf("tctrl_seq%0d", i), 32'hD8, seq_ctl[i]);
         if (i < 7) step();
      end
      wr(32'hD8, 32'h2);
      rd("tctrl_stop", 32'hD8, 32'h0);
      rd("tcount_stop", 32'hD4, 32'd2);
      step();
      rd("tcount_hold2", 32'hD4, 32'd2);
      wr(32'hD4, 32'd0);
      wr(32'hD8, 32'd1);
      wr(32'hD8, 32'd3);
      rd("expire_beats_clr", 32'hD8, 32'h3);
      rd("expire_reload", 32'hD4, 32'd3);
      wr(32'hD4, 32'd10);
      rd("wr_beats_dec", 32'hD4, 32'd10);
      step();
      rd("dec_after_wr", 32'hD4, 32'd9);
      wr(32'hD8, 32'd1);
      rd("bit1_zero_keep", 32'hD8, 32'h3);
      wr(32'hD8, 32'd0);
      rd("disable_keep_exp", 32'hD8, 32'h2);

      // Reset while timer free-runs with TRELOAD=0
      wr(32'hCC, 32'h5);
      wr(32'hD0, 32'h12);
      wr(32'hDC, 32'd0);
      wr(32'hD4, 32'd0);
      wr(32'hD8, 32'd1);
      step(); step();
      rd("run_tctrl", 32'hD8, 32'h3);
      rd("run_tcount", 32'hD4, 32'h0);
      resetn = 1'b0; addr = 32'hCC; datain = 32'h3FF; wmem = 1'b1;
      step();
      resetn = 1'b1; wmem = 1'b0;
      rd("prst_tcount", 32'hD4, 32'h0);
      rd("prst_tctrl", 32'hD8, 32'h0);
      rd("prst_led", 32'hCC, 32'h0);
      rd("prst_hex", 32'hD0, 32'h0);
      chk("prst_hex0", 64'(hex0), 64'h40);
      repeat (3) step();
      rd("prst_noexp", 32'hD8, 32'h0);

      // Randomized traffic against the reference model
      sw = '0; key = 3'b111;
      do_reset();
      m_reset();
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 4) == 0) ra = $urandom;
         else ra = 32'hC0 + 32'($urandom_range(0, 63));
         rw = ($urandom_range(0, 2) == 0);
         if (ra[5:2] == 4'd5 || ra[5:2] == 4'd7) rd_v = 32'($urandom_range(0, 6));
         else rd_v = $urandom;
         if ($urandom_range(0, 3) == 0) sw = 10'($urandom);
         if ($urandom_range(0, 5) == 0) key = key ^ (3'b001 << $urandom_range(0, 2));
         addr = ra; datain = rd_v; wmem = rw;
         #1;
         chk("rnd_sel", 64'(io_sel), 64'(ra[31:6] == 26'h3));
         chk("rnd_rd", 64'(dataout), 64'(m_read(ra)));
         chk("rnd_led", 64'(led), 64'(m_led));
         chk("rnd_hex", 64'({hex5, hex4, hex3, hex2, hex1, hex0}), 64'(hex_all(m_hex)));
         step();
         m_edge(ra, rd_v, rw, sw, key);
      end
      wmem = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
